// File: rtl/memory_access_arbiter.sv
// Shares the memory controller data port between the core load/store unit and the DMA port:
// arbitrates, steps the controller through LOAD or STORE_PRELOAD->STORE, returns data and status.

typedef enum logic [1:0] {
    NOP           = 2'd0,
    LOAD          = 2'd1,
    STORE_PRELOAD = 2'd2,
    STORE         = 2'd3
} MemoryMode_t;

module memory_access_arbiter #(
    parameter bit CORE_FIXED_PRIORITY = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        coreReq,
    input  logic        coreStore,
    input  logic [2:0]  coreFunct3,
    input  logic [31:0] coreRs1,
    input  logic [31:0] coreImm,
    input  logic [31:0] coreRs2,
    output logic        coreGnt,
    output logic        coreDone,
    output logic        coreErr,
    input  logic        dmaReq,
    input  logic        dmaStore,
    input  logic [2:0]  dmaFunct3,
    input  logic [31:0] dmaAddr,
    input  logic [31:0] dmaWData,
    output logic        dmaGnt,
    output logic        dmaDone,
    output logic        dmaErr,
    output logic [31:0] rdata,
    output MemoryMode_t memoryMode,
    output logic [2:0]  funct3,
    output logic [31:0] rs1,
    output logic [31:0] immediateI,
    output logic [31:0] immediateS,
    output logic [31:0] rs2,
    input  logic [31:0] memoryOutput,
    input  logic        memoryUnalignedAccess
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_D  = 3'd2,
        ST_PRELOAD = 3'd3,
        ST_STORE   = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    state_t      state_r, state_s;
    MemoryMode_t mode_r, mode_s;
    logic        owner_r, owner_s;        // 1 = DMA owns the current operation
    logic        last_grant_r;            // 1 = DMA was granted last
    logic        pick_dma_s, grant_s, err_s, resp_entry_s;
    logic        win_store_s;
    logic [2:0]  win_funct3_s;
    logic [2:0]  funct3_r;
    logic [31:0] rs1_r, imm_r, rs2_r, rdata_r;
    logic        core_done_r, dma_done_r, core_err_r, dma_err_r;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            funct3_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end else begin
            funct3_legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        end
    endfunction

    // Arbitration winner; on a round-robin tie the side not granted last wins
    always_comb begin
        pick_dma_s = 1'b0;
        if (dmaReq && !coreReq) begin
            pick_dma_s = 1'b1;
        end else if (dmaReq && coreReq && !CORE_FIXED_PRIORITY && !last_grant_r) begin
            pick_dma_s = 1'b1;
        end else begin
            pick_dma_s = 1'b0;
        end
    end

    assign grant_s = reset && (state_r == ST_IDLE) && (coreReq || dmaReq);
    assign coreGnt = grant_s && !pick_dma_s;
    assign dmaGnt  = grant_s && pick_dma_s;

    // Winner's command fields used for the legality check at grant time
    always_comb begin
        win_store_s  = 1'b0;
        win_funct3_s = 3'b000;
        if (pick_dma_s) begin
            win_store_s  = dmaStore;
            win_funct3_s = dmaFunct3;
        end else begin
            win_store_s  = coreStore;
            win_funct3_s = coreFunct3;
        end
    end

    // Next-state logic and error detection
    always_comb begin
        state_s = state_r;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!grant_s) begin
                    state_s = ST_IDLE;
                end else if (!funct3_legal(win_store_s, win_funct3_s)) begin
                    state_s = ST_RESP;
                    err_s   = 1'b1;
                end else if (win_store_s) begin
                    state_s = ST_PRELOAD;
                end else begin
                    state_s = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                if (memoryUnalignedAccess) begin
                    state_s = ST_RESP;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_LOAD_D;
                end
            end
            ST_LOAD_D:  state_s = ST_RESP;
            ST_PRELOAD: begin
                if (memoryUnalignedAccess) begin
                    state_s = ST_RESP;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_STORE;
                end
            end
            ST_STORE:   state_s = ST_RESP;
            ST_RESP:    state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // Controller mode for the upcoming state, registered so the port is glitch-free
    always_comb begin
        mode_s = NOP;
        case (state_s)
            ST_LOAD_A, ST_LOAD_D: mode_s = LOAD;
            ST_PRELOAD:           mode_s = STORE_PRELOAD;
            ST_STORE:             mode_s = STORE;
            default:              mode_s = NOP;
        endcase
    end

    assign owner_s      = grant_s ? pick_dma_s : owner_r;
    assign resp_entry_s = (state_s == ST_RESP);

    // State, operand, response and arbitration registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            mode_r       <= NOP;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            funct3_r     <= 3'd0;
            rs1_r        <= 32'd0;
            imm_r        <= 32'd0;
            rs2_r        <= 32'd0;
            rdata_r      <= 32'd0;
            core_done_r  <= 1'b0;
            dma_done_r   <= 1'b0;
            core_err_r   <= 1'b0;
            dma_err_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            mode_r      <= mode_s;
            owner_r     <= owner_s;
            core_done_r <= resp_entry_s && !owner_s;
            dma_done_r  <= resp_entry_s && owner_s;
            core_err_r  <= resp_entry_s && !owner_s && err_s;
            dma_err_r   <= resp_entry_s && owner_s && err_s;
            if (grant_s) begin
                last_grant_r <= pick_dma_s;
                funct3_r     <= win_funct3_s;
                rs1_r        <= pick_dma_s ? dmaAddr : coreRs1;
                imm_r        <= pick_dma_s ? 32'd0 : coreImm;
                rs2_r        <= pick_dma_s ? dmaWData : coreRs2;
            end
            if (state_r == ST_LOAD_D) begin
                rdata_r <= memoryOutput;
            end
        end
    end

    // Reset overrides the mode immediately so a STORE cycle never writes under reset
    always_comb begin
        if (reset) begin
            memoryMode = mode_r;
        end else begin
            memoryMode = NOP;
        end
    end

    assign funct3     = funct3_r;
    assign rs1        = rs1_r;
    assign immediateI = imm_r;
    assign immediateS = imm_r;
    assign rs2        = rs2_r;
    assign rdata      = rdata_r;
    assign coreDone   = core_done_r;
    assign coreErr    = core_err_r;
    assign dmaDone    = dma_done_r;
    assign dmaErr     = dma_err_r;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Directed bench for memory_access_arbiter with a small memory-controller model; a second
// instance with core fixed priority shares the request inputs for the arbitration check.

module tb_memory_access_arbiter;

    localparam logic [1:0] M_NOP   = 2'd0;
    localparam logic [1:0] M_LOAD  = 2'd1;
    localparam logic [1:0] M_PRE   = 2'd2;
    localparam logic [1:0] M_STORE = 2'd3;

    logic        clock = 1'b0;
    logic        reset;
    logic        coreReq, coreStore, dmaReq, dmaStore;
    logic [2:0]  coreFunct3, dmaFunct3;
    logic [31:0] coreRs1, coreImm, coreRs2, dmaAddr, dmaWData;
    logic        coreGnt, coreDone, coreErr, dmaGnt, dmaDone, dmaErr;
    logic [31:0] rdata, rs1, immediateI, immediateS, rs2;
    logic [2:0]  funct3;
    logic [1:0]  mode;
    logic [31:0] memoryOutput;
    logic        memoryUnalignedAccess;

    logic        c2_gnt, c2_done, c2_err, d2_gnt, d2_done, d2_err;
    logic [31:0] rdata2, rs1_2, immi_2, imms_2, rs2_2;
    logic [2:0]  funct3_2;
    logic [1:0]  mode2;

    logic [31:0] mem [0:255];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx = 8'd0;
    logic [31:0] poke_val = 32'd0;
    logic [31:0] addr_m, word_m, shifted_m, wmask_m, wdata_m;
    logic [4:0]  sh_m;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    memory_access_arbiter dut (
        .clock(clock), .reset(reset),
        .coreReq(coreReq), .coreStore(coreStore), .coreFunct3(coreFunct3), .coreRs1(coreRs1),
        .coreImm(coreImm), .coreRs2(coreRs2), .coreGnt(coreGnt), .coreDone(coreDone), .coreErr(coreErr),
        .dmaReq(dmaReq), .dmaStore(dmaStore), .dmaFunct3(dmaFunct3), .dmaAddr(dmaAddr),
        .dmaWData(dmaWData), .dmaGnt(dmaGnt), .dmaDone(dmaDone), .dmaErr(dmaErr),
        .rdata(rdata), .memoryMode(mode), .funct3(funct3), .rs1(rs1), .immediateI(immediateI),
        .immediateS(immediateS), .rs2(rs2), .memoryOutput(memoryOutput),
        .memoryUnalignedAccess(memoryUnalignedAccess)
    );

    memory_access_arbiter #(.CORE_FIXED_PRIORITY(1'b1)) dut_fixed (
        .clock(clock), .reset(reset),
        .coreReq(coreReq), .coreStore(coreStore), .coreFunct3(coreFunct3), .coreRs1(coreRs1),
        .coreImm(coreImm), .coreRs2(coreRs2), .coreGnt(c2_gnt), .coreDone(c2_done), .coreErr(c2_err),
        .dmaReq(dmaReq), .dmaStore(dmaStore), .dmaFunct3(dmaFunct3), .dmaAddr(dmaAddr),
        .dmaWData(dmaWData), .dmaGnt(d2_gnt), .dmaDone(d2_done), .dmaErr(d2_err),
        .rdata(rdata2), .memoryMode(mode2), .funct3(funct3_2), .rs1(rs1_2), .immediateI(immi_2),
        .immediateS(imms_2), .rs2(rs2_2), .memoryOutput(32'd0), .memoryUnalignedAccess(1'b0)
    );

    // Memory controller model: address decode, load extraction, alignment and store merge
    always_comb begin
        if (mode == M_PRE || mode == M_STORE) addr_m = rs1 + immediateS;
        else                                  addr_m = rs1 + immediateI;
        word_m    = mem[addr_m[9:2]];
        sh_m      = {addr_m[1:0], 3'b000};
        shifted_m = word_m >> sh_m;
        case (funct3[1:0])
            2'b00: begin
                memoryOutput = funct3[2] ? {24'd0, shifted_m[7:0]} : {{24{shifted_m[7]}}, shifted_m[7:0]};
                wmask_m      = 32'h0000_00FF << sh_m;
            end
            2'b01: begin
                memoryOutput = funct3[2] ? {16'd0, shifted_m[15:0]} : {{16{shifted_m[15]}}, shifted_m[15:0]};
                wmask_m      = 32'h0000_FFFF << sh_m;
            end
            default: begin
                memoryOutput = word_m;
                wmask_m      = 32'hFFFF_FFFF;
            end
        endcase
        wdata_m = (word_m & ~wmask_m) | ((rs2 << sh_m) & wmask_m);
        memoryUnalignedAccess = ((funct3[1:0] == 2'b01) && addr_m[0]) ||
                                ((funct3[1:0] == 2'b10) && (addr_m[1:0] != 2'b00));
    end

    always @(posedge clock) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        else if (mode == M_STORE) mem[addr_m[9:2]] <= wdata_m;
    end

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        @(negedge clock);
        poke_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        coreReq = 1'b0; coreStore = 1'b0; coreFunct3 = 3'd0; coreRs1 = 32'd0; coreImm = 32'd0; coreRs2 = 32'd0;
        dmaReq = 1'b0; dmaStore = 1'b0; dmaFunct3 = 3'd0; dmaAddr = 32'd0; dmaWData = 32'd0;
        repeat (2) @(negedge clock);
        tests_run++;
        if ({coreGnt, dmaGnt, coreDone, dmaDone, coreErr, dmaErr} !== 6'b0) begin
            tests_failed++; $display("FAIL reset_handshake: got %b want 000000", {coreGnt, dmaGnt, coreDone, dmaDone, coreErr, dmaErr});
        end
        tests_run++;
        if (mode !== M_NOP) begin tests_failed++; $display("FAIL reset_mode: got %0d want 0", mode); end
        tests_run++;
        if ({rdata, rs1, rs2, immediateI, immediateS, funct3} !== 163'd0) begin
            tests_failed++; $display("FAIL reset_operands: rdata %h rs1 %h rs2 %h want all 0", rdata, rs1, rs2);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_core_load();
        poke(8'h41, 32'hDEAD_BEEF);
        coreReq = 1'b1; coreStore = 1'b0; coreFunct3 = 3'b010; coreRs1 = 32'h100; coreImm = 32'h4;
        #1;
        tests_run++;
        if (coreGnt !== 1'b1 || dmaGnt !== 1'b0 || mode !== M_NOP) begin
            tests_failed++; $display("FAIL load_grant: got gnt %b%b mode %0d want 10 mode 0", coreGnt, dmaGnt, mode);
        end
        @(negedge clock);
        coreReq = 1'b0;
        tests_run++;
        if (mode !== M_LOAD || rs1 !== 32'h100 || immediateI !== 32'h4) begin
            tests_failed++; $display("FAIL load_addr_phase: got mode %0d rs1 %h imm %h want 1 100 4", mode, rs1, immediateI);
        end
        @(negedge clock);
        tests_run++;
        if (mode !== M_LOAD || coreDone !== 1'b0) begin
            tests_failed++; $display("FAIL load_data_phase: got mode %0d done %b want 1 0", mode, coreDone);
        end
        @(negedge clock);
        tests_run++;
        if (coreDone !== 1'b1 || coreErr !== 1'b0 || dmaDone !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
            tests_failed++; $display("FAIL load_done: got done %b err %b rdata %h want 1 0 deadbeef", coreDone, coreErr, rdata);
        end
        @(negedge clock);
    endtask

    task automatic test_dma_store_byte();
        poke(8'h80, 32'h1122_3344);
        dmaReq = 1'b1; dmaStore = 1'b1; dmaFunct3 = 3'b000; dmaAddr = 32'h201; dmaWData = 32'hAB;
        #1;
        tests_run++;
        if (dmaGnt !== 1'b1 || coreGnt !== 1'b0) begin
            tests_failed++; $display("FAIL sb_grant: got core %b dma %b want 0 1", coreGnt, dmaGnt);
        end
        @(negedge clock);
        dmaReq = 1'b0;
        tests_run++;
        if (mode !== M_PRE || rs1 !== 32'h201 || immediateS !== 32'd0 || rs2 !== 32'hAB) begin
            tests_failed++; $display("FAIL sb_preload: got mode %0d rs1 %h imm %h rs2 %h want 2 201 0 ab", mode, rs1, immediateS, rs2);
        end
        @(negedge clock);
        tests_run++;
        if (mode !== M_STORE) begin tests_failed++; $display("FAIL sb_store: got mode %0d want 3", mode); end
        @(negedge clock);
        tests_run++;
        if (dmaDone !== 1'b1 || dmaErr !== 1'b0 || coreDone !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
            tests_failed++; $display("FAIL sb_done: got done %b err %b rdata %h want 1 0 deadbeef", dmaDone, dmaErr, rdata);
        end
        tests_run++;
        if (mem[8'h80] !== 32'h1122_AB44) begin tests_failed++; $display("FAIL sb_memory: got %h want 1122ab44", mem[8'h80]); end
        @(negedge clock);
        coreReq = 1'b1; coreStore = 1'b0; coreFunct3 = 3'b010; coreRs1 = 32'h200; coreImm = 32'd0;
        #1;
        tests_run++;
        if (coreGnt !== 1'b1) begin tests_failed++; $display("FAIL lw_after_sb_grant: got %b want 1", coreGnt); end
        @(negedge clock);
        coreReq = 1'b0;
        repeat (2) @(negedge clock);
        tests_run++;
        if (coreDone !== 1'b1 || rdata !== 32'h1122_AB44) begin
            tests_failed++; $display("FAIL lw_after_sb: got done %b rdata %h want 1 1122ab44", coreDone, rdata);
        end
        @(negedge clock);
    endtask

    task automatic test_unaligned_store();
        poke(8'h40, 32'hCAFE_F00D);
        coreReq = 1'b1; coreStore = 1'b1; coreFunct3 = 3'b010; coreRs1 = 32'h102; coreImm = 32'd0; coreRs2 = 32'h5555_5555;
        #1;
        tests_run++;
        if (coreGnt !== 1'b1) begin tests_failed++; $display("FAIL unaligned_grant: got %b want 1", coreGnt); end
        @(negedge clock);
        coreReq = 1'b0;
        tests_run++;
        if (mode !== M_PRE) begin tests_failed++; $display("FAIL unaligned_preload: got mode %0d want 2", mode); end
        @(negedge clock);
        tests_run++;
        if (coreDone !== 1'b1 || coreErr !== 1'b1 || mode !== M_NOP || rdata !== 32'h1122_AB44) begin
            tests_failed++; $display("FAIL unaligned_done: got done %b err %b mode %0d rdata %h want 1 1 0 1122ab44", coreDone, coreErr, mode, rdata);
        end
        @(negedge clock);
        tests_run++;
        if (mem[8'h40] !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL unaligned_memory: got %h want cafef00d", mem[8'h40]); end
    endtask

    task automatic test_illegal_funct3();
        coreReq = 1'b1; coreStore = 1'b0; coreFunct3 = 3'b011; coreRs1 = 32'h100; coreImm = 32'd0;
        #1;
        tests_run++;
        if (coreGnt !== 1'b1 || mode !== M_NOP) begin
            tests_failed++; $display("FAIL illegal_grant: got gnt %b mode %0d want 1 0", coreGnt, mode);
        end
        @(negedge clock);
        coreReq = 1'b0;
        tests_run++;
        if (coreDone !== 1'b1 || coreErr !== 1'b1 || dmaErr !== 1'b0 || mode !== M_NOP) begin
            tests_failed++; $display("FAIL illegal_done: got done %b err %b mode %0d want 1 1 0", coreDone, coreErr, mode);
        end
        @(negedge clock);
    endtask

    task automatic test_round_robin();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        coreReq = 1'b1; coreStore = 1'b0; coreFunct3 = 3'b010; coreRs1 = 32'h100; coreImm = 32'h4;
        dmaReq = 1'b1; dmaStore = 1'b0; dmaFunct3 = 3'b010; dmaAddr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            int waited;
            waited = 0;
            #1;
            while (!(coreGnt || dmaGnt) && waited < 8) begin
                @(negedge clock); #1; waited++;
            end
            tests_run++;
            if (waited >= 8) begin
                tests_failed++; $display("FAIL rr_grant_%0d: no grant within 8 cycles", i);
            end else if (coreGnt !== (i % 2 == 0) || dmaGnt !== (i % 2 != 0)) begin
                tests_failed++; $display("FAIL rr_grant_%0d: got core %b dma %b want core %b", i, coreGnt, dmaGnt, (i % 2 == 0));
            end
            tests_run++;
            if (c2_gnt !== 1'b1 || d2_gnt !== 1'b0) begin
                tests_failed++; $display("FAIL fixed_grant_%0d: got core %b dma %b want 1 0", i, c2_gnt, d2_gnt);
            end
            @(negedge clock);
        end
        coreReq = 1'b0; dmaReq = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset_mid_store();
        poke(8'hC0, 32'h0102_0304);
        dmaReq = 1'b1; dmaStore = 1'b1; dmaFunct3 = 3'b001; dmaAddr = 32'h300; dmaWData = 32'hBEEF;
        #1;
        tests_run++;
        if (dmaGnt !== 1'b1) begin tests_failed++; $display("FAIL sh_grant: got %b want 1", dmaGnt); end
        @(negedge clock);
        dmaReq = 1'b0;
        @(negedge clock);
        tests_run++;
        if (mode !== M_STORE) begin tests_failed++; $display("FAIL sh_store_phase: got mode %0d want 3", mode); end
        reset = 1'b0;
        #1;
        tests_run++;
        if (mode !== M_NOP) begin tests_failed++; $display("FAIL sh_reset_mode: got mode %0d want 0", mode); end
        @(negedge clock);
        tests_run++;
        if ({coreDone, dmaDone, coreErr, dmaErr} !== 4'b0 || rdata !== 32'd0 || rs1 !== 32'd0 || mode !== M_NOP) begin
            tests_failed++; $display("FAIL sh_reset_outputs: got done %b%b err %b%b rdata %h mode %0d want zero", coreDone, dmaDone, coreErr, dmaErr, rdata, mode);
        end
        tests_run++;
        if (mem[8'hC0] !== 32'h0102_0304) begin tests_failed++; $display("FAIL sh_reset_memory: got %h want 01020304", mem[8'hC0]); end
        reset = 1'b1;
        coreReq = 1'b1; coreStore = 1'b0; coreFunct3 = 3'b011;
        dmaReq = 1'b1; dmaStore = 1'b0; dmaFunct3 = 3'b010; dmaAddr = 32'h200;
        #1;
        tests_run++;
        if (coreGnt !== 1'b1 || dmaGnt !== 1'b0) begin
            tests_failed++; $display("FAIL post_reset_tie: got core %b dma %b want 1 0", coreGnt, dmaGnt);
        end
        @(negedge clock);
        coreReq = 1'b0; dmaReq = 1'b0;
        tests_run++;
        if (coreDone !== 1'b1 || dmaDone !== 1'b0) begin
            tests_failed++; $display("FAIL post_reset_done: got core %b dma %b want 1 0", coreDone, dmaDone);
        end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_core_load();
        test_dma_store_byte();
        test_unaligned_store();
        test_illegal_funct3();
        test_round_robin();
        test_reset_mid_store();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/memory_access_arbiter.md
# memory_access_arbiter

Sequences and shares the single data port of the memory controller between two requesters: the core's load/store unit and a DMA/debug port. Accepts one request at a time, drives the controller's `memoryMode`/addressing/store-data inputs through the required LOAD or STORE_PRELOAD→STORE sequence, and returns load data, completion and error status to the owning requester. Sits between the control logic/DMA and the memory controller; instruction fetch is unaffected.

## Interface
- `CORE_FIXED_PRIORITY`, default 0: 0 = round-robin arbitration; 1 = core always wins when both request.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low.
- `coreReq`  in  1  core request valid; `coreStore` in 1 (1 = store); `coreFunct3` in 3; `coreRs1` in 32; `coreImm` in 32 (I- or S-immediate per `coreStore`); `coreRs2` in 32 store data.
- `coreGnt` out 1 accept pulse; `coreDone` out 1 completion pulse; `coreErr` out 1 error, valid with `coreDone`.
- `dmaReq` in 1; `dmaStore` in 1; `dmaFunct3` in 3; `dmaAddr` in 32 byte address; `dmaWData` in 32.
- `dmaGnt` out 1; `dmaDone` out 1; `dmaErr` out 1.
- `rdata` out 32: load result, valid with either done pulse.
- `memoryMode` out MemoryMode_t; `funct3` out 3; `rs1` out 32; `immediateI` out 32; `immediateS` out 32; `rs2` out 32: to memory controller.
- `memoryOutput` in 32; `memoryUnalignedAccess` in 1: from memory controller.

## Operation
- States: IDLE, LOAD_A, LOAD_D, PRELOAD, STORE, RESP.
- IDLE: `memoryMode` = NOP. If any req high, arbiter picks a winner; its gnt is high combinationally in that cycle; its fields are latched at the edge into the operand registers along with an owner bit.
- Operand mapping: core → rs1 = coreRs1, immediateI = immediateS = coreImm, rs2 = coreRs2. DMA → rs1 = dmaAddr, immediates = 0, rs2 = dmaWData. Controller inputs come only from the operand registers.
- Legal funct3: loads 000/001/010/100/101; stores 000/001/010. An illegal funct3 is still granted, then IDLE→RESP with err = 1 and no access (memoryMode stays NOP).
- Load: LOAD_A (mode LOAD; sample `memoryUnalignedAccess`; if 1 → RESP, err = 1) → LOAD_D (mode LOAD held; capture `memoryOutput` into `rdata` at the edge) → RESP.
- Store (all widths): PRELOAD (mode STORE_PRELOAD; sample `memoryUnalignedAccess`; if 1 → RESP, err = 1, no write ever issued) → STORE (mode STORE for exactly one cycle, write at its ending edge) → RESP.
- RESP: owner's done = 1 for one cycle; err as recorded. Next state is IDLE. No grant in RESP.
- `rdata` holds its last value after stores and errors (it is written only in LOAD_D).
- Arbitration: `lastGrant` register. Round-robin tie goes to the requester not in `lastGrant`. A single requester always wins. `lastGrant` updates on every grant.
- Requester rules: fields must be stable while req is high and un-granted. Dropping req before gnt withdraws the request. Fields may change freely after gnt. Holding req through done is a new request, considered in the next IDLE.

## Timing
- Grant cycle N (IDLE). Load: done at N+3. Store: done at N+3. Unaligned: done at N+2. Illegal funct3: done at N+1.
- Throughput: one op per 4 cycles (loads/stores), since IDLE occupies one cycle between ops.
- Reset (sampled low at an edge): state → IDLE. All outputs → 0, except `memoryMode` → NOP. `lastGrant` → DMA, so the core wins the first tie.
- While `reset` is low, `memoryMode` is forced to NOP combinationally. A STORE cycle coinciding with asserted reset does not write.
- Reset mid-operation: the operation is dropped with no done pulse, and the requester must re-request.
- Gnt, done and err are never asserted for both requesters in the same cycle.

## Test plan
- Core lw, rs1 = 0x100, imm = 4, memory word at 0x104 = 0xDEADBEEF -> coreGnt at N, LOAD/LOAD at N+1/N+2, coreDone at N+3 with rdata = 0xDEADBEEF, coreErr = 0.
- DMA sb, addr 0x201, wdata 0xAB, word at 0x200 previously 0x11223344 -> STORE_PRELOAD at N+1, STORE at N+2, dmaDone at N+3; a subsequent lw at 0x200 returns the byte replaced at offset 1.
- Core sw with rs1 = 0x102 -> PRELOAD flags unaligned; coreDone + coreErr at N+2; memoryMode never equals STORE; memory unchanged.
- coreReq and dmaReq both high continuously, round-robin -> grants alternate core, DMA, core, DMA; with `CORE_FIXED_PRIORITY` = 1, core is granted every time.
- Core load, funct3 = 011 -> coreGnt at N, coreDone + coreErr at N+1, memoryMode NOP throughout.
- Reset driven low during the STORE cycle of a DMA sh -> no write (memory unchanged), no dmaDone, outputs zero/NOP at the next edge, and the next tie is granted to the core.
